hdr_sched: RTL and testbench

Frame-level sequencer for the `hdr` merge datapath. For each pixel index it fetches the three exposures (high, mid, low) from a shared single-port pixel memory, then presents the RGB565 triple to `hdr` with a one-cycle `hdr_start`. It collects the `lE_*` results on `hdr_done` into a small result FIFO and drains them to the output frame writer under valid/ready backpressure. It sits between the exposure frame buffers and the tone-map/output stage.

---
 rtl/hdr_pkg.sv | 24 ++
 rtl/hdr_res_fifo.sv | 46 ++++
 rtl/hdr_sched.sv | 176 +++++++++++++++++
 tb/tb_hdr_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR frame sequencer: exposure selects, FSM states, RGB565 layout.
package hdr_pkg;

    localparam logic [1:0] SEL_HIGH = 2'd0;
    localparam logic [1:0] SEL_MID  = 2'd1;
    localparam logic [1:0] SEL_LOW  = 2'd2;

    localparam int unsigned RGB_R_LSB = 11;
    localparam int unsigned RGB_G_LSB = 5;
    localparam int unsigned RGB_B_LSB = 0;
    localparam int unsigned RGB_R_W   = 5;
    localparam int unsigned RGB_G_W   = 6;
    localparam int unsigned RGB_B_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_COLLECT,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/hdr_res_fifo.sv
// Synchronous result FIFO with occupancy count; push and pop may coincide, including when full.
module hdr_res_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((32'(count) < 32'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hdr_sched.sv
// Frame sequencer: fetches three exposures per pixel, issues them to hdr, drains results.
// Optional statistics counters are built when HDR_SCHED_STATS_EN is defined.
module hdr_sched
    import hdr_pkg::*;
#(
    parameter int unsigned PIXELS     = 76800,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned HDR_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_req,
    output logic [1:0]        rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic [15:0]       pix_high,
    output logic [15:0]       pix_mid,
    output logic [15:0]       pix_low,
    output logic              hdr_start,
    input  logic              hdr_done,
    input  logic [7:0]        lE_red,
    input  logic [7:0]        lE_green,
    input  logic [7:0]        lE_blue,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    input  logic              wr_ready,
    output logic [31:0]       stat_cycles,
    output logic [31:0]       stat_stalls
);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INFL_W = $clog2(FIFO_DEPTH + HDR_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [1:0]        ret_cnt;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic [INFL_W-1:0] inflight;
    logic [FCNT_W-1:0] fifo_count;
    logic [23:0]       fifo_head;
    logic              accept;
    logic              credit_ok;
    logic              issue_fire;
    logic              done_ok;
    logic              wr_fire;
    logic              last_pop;
    logic              slots_full;
    logic              capture;

    assign accept     = rd_req && rd_ready;
    assign credit_ok  = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign issue_fire = (state == ST_ISSUE) && credit_ok;
    assign done_ok    = hdr_done && (inflight != '0);
    assign slots_full = (ret_cnt == 2'd3) || (rd_valid && (ret_cnt == 2'd2));
    assign capture    = rd_valid && (ret_cnt != 2'd3) && ((state == ST_REQ) || (state == ST_COLLECT));
    assign wr_valid   = (fifo_count != '0) && (state != ST_IDLE);
    assign wr_fire    = wr_valid && wr_ready;
    assign last_pop   = wr_fire && (wr_idx == LAST_IDX);
    assign wr_data    = wr_valid ? fifo_head : 24'd0;
    assign wr_addr    = wr_idx;
    assign rd_addr    = rd_idx;

    hdr_res_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (done_ok),
        .push_data ({lE_red, lE_green, lE_blue}),
        .pop       (wr_fire),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_REQ;
            ST_REQ:     if (accept && (rd_sel == SEL_LOW)) state_nxt = ST_COLLECT;
            ST_COLLECT: if (slots_full) state_nxt = ST_ISSUE;
            ST_ISSUE:   if (issue_fire) state_nxt = (rd_idx == LAST_IDX) ? ST_DRAIN : ST_REQ;
            ST_DRAIN:   if (last_pop) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Registered control outputs are loaded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rd_req     <= 1'b0;
            rd_sel     <= SEL_HIGH;
            hdr_start  <= 1'b0;
            ret_cnt    <= 2'd0;
            rd_idx     <= '0;
            wr_idx     <= '0;
            inflight   <= '0;
            pix_high   <= 16'd0;
            pix_mid    <= 16'd0;
            pix_low    <= 16'd0;
        end else begin
            busy       <= (state_nxt == ST_REQ) || (state_nxt == ST_COLLECT) ||
                          (state_nxt == ST_ISSUE) || (state_nxt == ST_DRAIN);
            frame_done <= (state_nxt == ST_DONE);
            rd_req     <= (state_nxt == ST_REQ);
            hdr_start  <= issue_fire;
            if ((state == ST_IDLE) && start) begin
                rd_idx   <= '0;
                wr_idx   <= '0;
                inflight <= '0;
                ret_cnt  <= 2'd0;
                rd_sel   <= SEL_HIGH;
            end else begin
                if (accept) rd_sel <= (rd_sel == SEL_LOW) ? SEL_HIGH : rd_sel + 2'd1;
                if (issue_fire) begin
                    rd_idx  <= rd_idx + ADDR_W'(1);
                    ret_cnt <= 2'd0;
                end else if (capture) begin
                    case (ret_cnt)
                        SEL_HIGH: pix_high <= rd_data;
                        SEL_MID:  pix_mid  <= rd_data;
                        default:  pix_low  <= rd_data;
                    endcase
                    ret_cnt <= ret_cnt + 2'd1;
                end
                if (wr_fire) wr_idx <= wr_idx + ADDR_W'(1);
                if (issue_fire && !done_ok)      inflight <= inflight + INFL_W'(1);
                else if (done_ok && !issue_fire) inflight <= inflight - INFL_W'(1);
            end
        end
    end

`ifdef HDR_SCHED_STATS_EN
    logic [31:0] cyc_cnt;
    logic [31:0] stall_cnt;

    // Saturating frame statistics, cleared when a new frame is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= 32'd0;
            stall_cnt <= 32'd0;
        end else if ((state == ST_IDLE) && start) begin
            cyc_cnt   <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (busy && (cyc_cnt != 32'hFFFF_FFFF)) cyc_cnt <= cyc_cnt + 32'd1;
            if ((state == ST_ISSUE) && !credit_ok && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stat_cycles = cyc_cnt;
    assign stat_stalls = stall_cnt;
`else
    assign stat_cycles = 32'd0;
    assign stat_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_hdr_sched.sv
// Directed bench for hdr_sched with a memory model, an hdr pipeline model and a write monitor.
module tb_hdr_sched;
    import hdr_pkg::*;

    localparam int unsigned PIX   = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, frame_done, rd_req, hdr_start, wr_valid;
    logic [1:0]    rd_sel;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_ready, rd_valid, hdr_done, wr_ready;
    logic [15:0]   rd_data, pix_high, pix_mid, pix_low;
    logic [7:0]    le_r, le_g, le_b;
    logic [23:0]   wr_data;
    logic [31:0]   stat_cycles, stat_stalls;

    hdr_sched #(.PIXELS(PIX), .ADDR_W(AW), .HDR_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .pix_high(pix_high), .pix_mid(pix_mid),
        .pix_low(pix_low), .hdr_start(hdr_start), .hdr_done(hdr_done), .lE_red(le_r),
        .lE_green(le_g), .lE_blue(le_b), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .stat_cycles(stat_cycles),
        .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [23:0] data;
    } ent_t;

    ent_t rdq[$];
    ent_t hq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rd_lat = 1;
    bit   rd_toggle = 1'b0;
    bit   wr_stall = 1'b0;
    bit   check_spacing = 1'b0;
    bit   check_latency = 1'b0;
    int   frm_starts = 0, frm_writes = 0, acc_cnt = 0, frame_dones = 0;
    int   last_start_cyc = 0, last_hs_cyc = 0;
    int   start_at[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_pix(input logic [1:0] sel, input int unsigned addr);
        logic [15:0] a;
        a = 16'(addr);
        case (sel)
            SEL_HIGH: return 16'hF800 ^ a;
            SEL_MID:  return 16'h07E0 ^ (a << 11);
            default:  return 16'h001F ^ (a << 5);
        endcase
    endfunction

    function automatic logic [23:0] hdr_f(input logic [15:0] h, input logic [15:0] m, input logic [15:0] l);
        logic [7:0] r, g, b;
        r = 8'(h[15:11]) + 8'(l[15:11]);
        g = 8'(m[10:5]) ^ 8'(h[4:0]);
        b = 8'(l[4:0]) + 8'(m[15:11]);
        return {r, g, b};
    endfunction

    function automatic logic [23:0] exp_res(input int unsigned idx);
        return hdr_f(mem_pix(SEL_HIGH, idx), mem_pix(SEL_MID, idx), mem_pix(SEL_LOW, idx));
    endfunction

    // Environment step: inputs for the current cycle are set mid-cycle, outputs observed.
    task automatic env_step();
        cyc++;
        if (rst) begin
            rdq.delete();
            hq.delete();
            rd_ready = 1'b0; rd_valid = 1'b0; rd_data = 16'd0;
            hdr_done = 1'b0; {le_r, le_g, le_b} = 24'd0; wr_ready = 1'b0;
            return;
        end
        rd_ready = rd_toggle ? ((cyc % 2) == 0) : 1'b1;
        wr_ready = !wr_stall;
        rd_valid = 1'b0;
        rd_data  = 16'd0;
        if (rdq.size() > 0 && rdq[0].due <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = rdq[0].data[15:0];
            void'(rdq.pop_front());
        end
        if (rd_req && rd_ready) begin
            chk("rd_sel order", 32'(rd_sel), 32'(acc_cnt % 3));
            chk("rd_addr", 32'(rd_addr), 32'(acc_cnt / 3));
            rdq.push_back('{due: cyc + rd_lat, data: 24'(mem_pix(rd_sel, 32'(rd_addr)))});
            acc_cnt++;
        end
        hdr_done = 1'b0;
        {le_r, le_g, le_b} = 24'd0;
        if (hq.size() > 0 && hq[0].due <= cyc) begin
            hdr_done = 1'b1;
            {le_r, le_g, le_b} = hq[0].data;
            void'(hq.pop_front());
        end
        if (hdr_start) begin
            chk("pix_high", 32'(pix_high), 32'(mem_pix(SEL_HIGH, frm_starts)));
            chk("pix_mid", 32'(pix_mid), 32'(mem_pix(SEL_MID, frm_starts)));
            chk("pix_low", 32'(pix_low), 32'(mem_pix(SEL_LOW, frm_starts)));
            if (check_spacing && frm_starts > 0)
                chk("hdr_start spacing", 32'(cyc - last_start_cyc), 32'd5);
            chk("credit bound", 32'((frm_starts + 1 - frm_writes) <= int'(DEPTH)), 32'd1);
            start_at[frm_starts % 16] = cyc;
            last_start_cyc = cyc;
            hq.push_back('{due: cyc + int'(LAT), data: hdr_f(pix_high, pix_mid, pix_low)});
            frm_starts++;
        end
        if (wr_valid && wr_ready) begin
            chk("wr_addr order", 32'(wr_addr), 32'(frm_writes));
            chk("wr_data", 32'(wr_data), 32'(exp_res(frm_writes)));
            if (check_latency)
                chk("result latency", 32'(cyc - start_at[frm_writes % 16]), 32'(LAT + 1));
            last_hs_cyc = cyc;
            frm_writes++;
        end
        if (frame_done) begin
            frame_dones++;
            chk("busy low at frame_done", 32'(busy), 32'd0);
            chk("frame_done after last write", 32'(cyc - last_hs_cyc), 32'd1);
        end
    endtask

    initial begin
        rd_ready = 1'b0; rd_valid = 1'b0; rd_data = 16'd0;
        hdr_done = 1'b0; {le_r, le_g, le_b} = 24'd0; wr_ready = 1'b0;
        forever @(negedge clk) env_step();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_reset_outputs(input string p);
        chk({p, " busy"}, 32'(busy), 32'd0);
        chk({p, " frame_done"}, 32'(frame_done), 32'd0);
        chk({p, " rd_req"}, 32'(rd_req), 32'd0);
        chk({p, " hdr_start"}, 32'(hdr_start), 32'd0);
        chk({p, " wr_valid"}, 32'(wr_valid), 32'd0);
        chk({p, " rd_sel"}, 32'(rd_sel), 32'd0);
        chk({p, " rd_addr"}, 32'(rd_addr), 32'd0);
        chk({p, " pix_high"}, 32'(pix_high), 32'd0);
        chk({p, " pix_mid"}, 32'(pix_mid), 32'd0);
        chk({p, " pix_low"}, 32'(pix_low), 32'd0);
        chk({p, " wr_addr"}, 32'(wr_addr), 32'd0);
        chk({p, " wr_data"}, 32'(wr_data), 32'd0);
        chk({p, " stat_cycles"}, stat_cycles, 32'd0);
        chk({p, " stat_stalls"}, stat_stalls, 32'd0);
    endtask

    task automatic new_frame();
        frm_starts = 0;
        frm_writes = 0;
        acc_cnt    = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int base;
        base = frame_dones;
        for (int i = 0; i < budget && frame_dones == base; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk({tag, " frame_done count"}, 32'(frame_dones - base), 32'd1);
        chk({tag, " writes"}, 32'(frm_writes), 32'(PIX));
        chk({tag, " issues"}, 32'(frm_starts), 32'(PIX));
        chk({tag, " busy after frame"}, 32'(busy), 32'd0);
`ifdef HDR_SCHED_STATS_EN
        chk({tag, " stat_cycles nonzero"}, 32'(stat_cycles != 32'd0), 32'd1);
`else
        chk({tag, " stat_cycles"}, stat_cycles, 32'd0);
        chk({tag, " stat_stalls"}, stat_stalls, 32'd0);
`endif
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame: full-rate reads and writes.
        rd_lat = 1; rd_toggle = 1'b0; wr_stall = 1'b0;
        check_spacing = 1'b1; check_latency = 1'b1;
        new_frame();
        chk("idle busy", 32'(busy), 32'd0);
        pulse_start();
        chk("busy after start", 32'(busy), 32'd1);
        chk("rd_req after start", 32'(rd_req), 32'd1);
        chk("rd_sel after start", 32'(rd_sel), 32'(SEL_HIGH));
        wait_frame("nominal", 400);

        // Toggling read acceptance with 3-cycle read latency.
        rd_lat = 3; rd_toggle = 1'b1; check_spacing = 1'b0;
        new_frame();
        pulse_start();
        wait_frame("slow reads", 600);

        // Output stalled for 40 cycles: issue must stop at the credit limit.
        rd_lat = 1; rd_toggle = 1'b0; wr_stall = 1'b1; check_latency = 1'b0;
        new_frame();
        pulse_start();
        repeat (40) @(negedge clk);
        chk("stall issues", 32'(frm_starts), 32'(DEPTH));
        chk("stall writes", 32'(frm_writes), 32'd0);
        chk("stall wr_valid", 32'(wr_valid), 32'd1);
`ifdef HDR_SCHED_STATS_EN
        chk("stat_stalls nonzero", 32'(stat_stalls != 32'd0), 32'd1);
`else
        chk("stat_stalls off", stat_stalls, 32'd0);
`endif
        wr_stall = 1'b0;
        wait_frame("backpressure", 600);

        // Extra start mid-frame must be ignored.
        check_spacing = 1'b1; check_latency = 1'b1;
        new_frame();
        pulse_start();
        repeat (12) @(negedge clk);
        pulse_start();
        chk("busy after mid start", 32'(busy), 32'd1);
        wait_frame("mid start", 400);

        // Reset during DRAIN, then a clean frame.
        new_frame();
        pulse_start();
        n = 0;
        while (frm_starts < int'(PIX) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reached drain", 32'(frm_starts), 32'(PIX));
        base = frame_dones;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("drain reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no frame_done after reset", 32'(frame_dones - base), 32'd0);
        chk("idle after reset", 32'(busy), 32'd0);
        new_frame();
        pulse_start();
        wait_frame("after reset", 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
